// File: rtl/clk_gate_pkg.sv
// Shared definitions for the per-domain clock gating controller:
// FSM state encoding, counter width and parameter defaults.
package clk_gate_pkg;

  localparam int CNT_W         = 8;
  localparam int N_DOM_DEF     = 4;
  localparam int WAKE_CYC_DEF  = 2;
  localparam int IDLE_CYC_DEF  = 16;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_WAKE      = 2'd1,
    ST_ON        = 2'd2,
    ST_IDLE_WAIT = 2'd3
  } dom_state_e;

  // Reload value for a countdown lasting 'cyc' cycles (counter runs cyc-1 .. 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: enable captured by a latch that is transparent
// while CLK is low, then ANDed with CLK. Because the latch is closed for the
// whole high phase, neither an enable change nor RST can shorten a pulse that
// has already started.
module clk_gate_cell (
  input  logic CLK,
  input  logic RST,
  input  logic En,
  output logic Gated_CLK
);

  logic r_en_lat;

  // Low-transparent enable latch; reset is applied through the open latch so
  // a running high phase always completes at full width.
  always_latch begin
    if (!CLK) begin
      if (RST) begin
        r_en_lat <= 1'b0;
      end else begin
        r_en_lat <= En;
      end
    end
  end

  assign Gated_CLK = CLK & r_en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock gating controller. Each domain runs an OFF/WAKE/ON/IDLE_WAIT
// FSM with an 8-bit down-counter that produces registered Clk_En and Ack, and
// drives one clk_gate_cell. Force_On bypasses the gate enables only; the FSMs
// keep running untouched.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_DOM    = N_DOM_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_DOM-1:0] Req,
  input  logic             Force_On,
  output logic [N_DOM-1:0] Ack,
  output logic [N_DOM-1:0] Clk_En,
  output logic [N_DOM-1:0] Gated_CLK,
  output logic             Busy
);

  localparam logic [CNT_W-1:0] LD_WAKE = cnt_load(WAKE_CYC);
  localparam logic [CNT_W-1:0] LD_IDLE = cnt_load(IDLE_CYC);

  // Gate latches are only cleared by reset when Force_On is not overriding,
  // so the override keeps clocks running even while the FSMs are held in reset.
  logic w_cell_rst;
  assign w_cell_rst = RST & ~Force_On;

  for (genvar g = 0; g < N_DOM; g++) begin : g_dom

    dom_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack;
    logic             r_clk_en;
    logic             w_gate_en;

    // Domain FSM: wake countdown, grant, idle countdown before gating off.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_state  <= ST_OFF;
        r_cnt    <= CNT_ZERO;
        r_ack    <= 1'b0;
        r_clk_en <= 1'b0;
      end else begin
        case (r_state)
          ST_OFF: begin
            if (Req[g]) begin
              r_state  <= ST_WAKE;
              r_cnt    <= LD_WAKE;
              r_clk_en <= 1'b1;
              r_ack    <= 1'b0;
            end else begin
              r_clk_en <= 1'b0;
              r_ack    <= 1'b0;
            end
          end
          ST_WAKE: begin
            // A request that drops mid-wake still finishes the wake period.
            if (r_cnt != CNT_ZERO) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else if (Req[g]) begin
              r_state <= ST_ON;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_IDLE_WAIT;
              r_cnt   <= LD_IDLE;
            end
          end
          ST_ON: begin
            if (!Req[g]) begin
              r_state <= ST_IDLE_WAIT;
              r_cnt   <= LD_IDLE;
              r_ack   <= 1'b0;
            end else begin
              r_ack   <= 1'b1;
            end
          end
          ST_IDLE_WAIT: begin
            // Clock is still running here, so a returning request is granted
            // immediately; it also beats a simultaneous timeout.
            if (Req[g]) begin
              r_state <= ST_ON;
              r_ack   <= 1'b1;
            end else if (r_cnt == CNT_ZERO) begin
              r_state  <= ST_OFF;
              r_clk_en <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          default: begin
            r_state  <= ST_OFF;
            r_cnt    <= CNT_ZERO;
            r_ack    <= 1'b0;
            r_clk_en <= 1'b0;
          end
        endcase
      end
    end

    assign Ack[g]    = r_ack;
    assign Clk_En[g] = r_clk_en;
    assign w_gate_en = r_clk_en | Force_On;

    clk_gate_cell u_gate (
      .CLK       (CLK),
      .RST       (w_cell_rst),
      .En        (w_gate_en),
      .Gated_CLK (Gated_CLK[g])
    );

  end

  assign Busy = |Clk_En;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl (default parameters). The stimulus process
// drives Req once per cycle from a directed timeline and pushes the
// hand-derived expected outputs for that edge; a monitor pops and compares
// shortly after each rising edge. Reset and Force_On corner cases are checked
// directly, and every Gated_CLK pulse is width-checked.
module tb_clk_gate_ctrl;

  localparam int N = 4;
  localparam int HALF = 5;

  logic         CLK;
  logic         RST;
  logic [N-1:0] Req;
  logic         Force_On;
  logic [N-1:0] Ack;
  logic [N-1:0] Clk_En;
  logic [N-1:0] Gated_CLK;
  logic         Busy;

  int total = 0;
  int bad   = 0;
  int edge_k = 0;

  typedef struct {
    int           k;
    logic [N-1:0] ack;
    logic [N-1:0] en;
    logic [N-1:0] gated;
    logic         busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  clk_gate_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req       (Req),
    .Force_On  (Force_On),
    .Ack       (Ack),
    .Clk_En    (Clk_En),
    .Gated_CLK (Gated_CLK),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #HALF CLK = ~CLK;

  // Edge number: edge k is the k-th rising edge of CLK.
  always @(posedge CLK) edge_k <= edge_k + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Directed timeline: d2 one-cycle pulse at edge 5; d0 high edges 10..19;
  // d1 high edges 10..19 and again from edge 30; d3 idle.
  function automatic logic [N-1:0] req_at(input int k);
    logic [N-1:0] r;
    r    = 4'b0000;
    r[0] = (k >= 10 && k < 20);
    r[1] = (k >= 10 && k < 20) || (k >= 30);
    r[2] = (k == 5);
    return r;
  endfunction

  // Expected Clk_En after edge k (wake at t, idle-off at t+16 from Req low).
  function automatic logic [N-1:0] en_at(input int k);
    logic [N-1:0] r;
    r    = 4'b0000;
    r[0] = (k >= 10 && k < 36);
    r[1] = (k >= 10);
    r[2] = (k >= 5 && k < 23);
    return r;
  endfunction

  // Expected Ack after edge k (grant at t+2, immediate re-grant from idle).
  function automatic logic [N-1:0] ack_at(input int k);
    logic [N-1:0] r;
    r    = 4'b0000;
    r[0] = (k >= 12 && k < 20);
    r[1] = (k >= 12 && k < 20) || (k >= 30);
    return r;
  endfunction

  // Scoreboard monitor: compare the oldest expectation once its edge arrives.
  always @(posedge CLK) begin
    #2;
    if (sb_q.size() > 0 && sb_q[0].k == edge_k) begin
      mon_e = sb_q.pop_front();
      chk($sformatf("edge%0d ack_en_gated_busy", mon_e.k),
          {19'd0, Ack, Clk_En, Gated_CLK, Busy},
          {19'd0, mon_e.ack, mon_e.en, mon_e.gated, mon_e.busy});
    end
  end

  // Pulse-width monitor: every Gated_CLK high phase must last a full half period.
  for (genvar i = 0; i < N; i++) begin : g_pw
    time t_rise;
    always @(posedge Gated_CLK[i]) t_rise <= $time;
    always @(negedge Gated_CLK[i]) chk($sformatf("pulse_width_d%0d", i), 32'($time - t_rise), 32'(HALF));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    RST = 1'b1;
    Req = 4'b0000;
    Force_On = 1'b0;

    @(negedge CLK);
    #1;
    chk("reset_state", {20'd0, Ack, Clk_En, Gated_CLK}, 32'd0);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Main timeline: drive Req for the next edge and queue its expectation.
    while (edge_k < 45) begin
      e.k     = edge_k + 1;
      e.ack   = ack_at(e.k);
      e.en    = en_at(e.k);
      e.gated = en_at(e.k - 1);
      e.busy  = |en_at(e.k);
      Req = req_at(e.k);
      sb_q.push_back(e);
      @(negedge CLK);
    end

    // Reset while d1 is ON, asserted mid high phase: outputs drop at once,
    // the running pulse completes, and the next phase is gated off.
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_on_outputs", {24'd0, Ack, Clk_En}, 32'd0);
    chk("rst_on_busy", {31'd0, Busy}, 32'd0);
    chk("rst_on_pulse_kept", {28'd0, Gated_CLK}, 32'h2);
    @(posedge CLK);
    #2;
    chk("rst_on_next_gated", {28'd0, Gated_CLK}, 32'd0);

    // All domains requested, then reset mid-WAKE.
    @(negedge CLK);
    RST = 1'b0;
    Req = 4'b1111;
    @(posedge CLK);
    #2;
    chk("all_wake_en", {24'd0, Ack, Clk_En}, 32'h0F);
    @(posedge CLK);
    #2;
    chk("all_wake_gated", {24'd0, Ack, Gated_CLK}, 32'h0F);
    RST = 1'b1;
    #1;
    chk("rst_wake_outputs", {23'd0, Ack, Clk_En, Busy}, 32'd0);
    chk("rst_wake_pulse_kept", {28'd0, Gated_CLK}, 32'hF);
    @(posedge CLK);
    #2;
    chk("rst_wake_next_gated", {28'd0, Gated_CLK}, 32'd0);

    // First edge after reset release samples Req normally.
    @(negedge CLK);
    RST = 1'b0;
    Req = 4'b1000;
    @(posedge CLK);
    #2;
    chk("post_rst_sample", {24'd0, Ack, Clk_En}, 32'h08);
    @(negedge CLK);
    RST = 1'b1;
    Req = 4'b0000;
    #1;
    chk("clear_again", {28'd0, Clk_En}, 32'd0);

    // Force_On with no requests: clocks run, FSM outputs stay low.
    @(negedge CLK);
    RST = 1'b0;
    Force_On = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #2;
      chk($sformatf("force_gated_%0d", i), {28'd0, Gated_CLK}, 32'hF);
      chk($sformatf("force_fsm_%0d", i), {23'd0, Ack, Clk_En, Busy}, 32'd0);
    end
    Force_On = 1'b0;
    #1;
    chk("force_drop_pulse_kept", {28'd0, Gated_CLK}, 32'hF);
    @(posedge CLK);
    #2;
    chk("force_off_gated", {28'd0, Gated_CLK}, 32'd0);

    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter N_DOM, default 4, number of independently gated clock domains.
REQ-002 Parameter WAKE_CYC, default 2, cycles from enable assertion to Ack; legal range 1..255.
REQ-003 Parameter IDLE_CYC, default 16, cycles of Req low before gating off; legal range 1..255.
REQ-004 CLK  input  1  single free-running source clock; all logic on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 Req  input  N_DOM  per-domain clock request, synchronous to CLK.
REQ-007 Force_On  input  1  test/debug override: all gated clocks run while high.
REQ-008 Ack  output  N_DOM  per-domain registered grant: the gated clock is stable and running.
REQ-009 Clk_En  output  N_DOM  per-domain registered gate enable, before the latch.
REQ-010 Gated_CLK  output  N_DOM  per-domain glitch-free gated clock.
REQ-011 Busy  output  1  OR of all Clk_En bits.

Function
REQ-012 Each domain SHALL have an independent FSM with states OFF, WAKE, ON and IDLE_WAIT, plus an 8-bit down-counter.
REQ-013 OFF: Clk_En=0, Ack=0; Req sampled high at edge t -> WAKE, Clk_En=1 after t, counter loaded with WAKE_CYC-1.
REQ-014 WAKE: Clk_En=1, Ack=0; counter decrements each cycle; at zero -> ON (Ack=1) if Req=1, else -> IDLE_WAIT with counter loaded IDLE_CYC-1.
REQ-015 Wake latency: Req first sampled high at edge t SHALL give Ack=1 after edge t+WAKE_CYC, provided Req stays high.
REQ-016 ON: Clk_En=1, Ack=1; Req sampled low at edge t -> IDLE_WAIT, Ack=0 after t, counter loaded IDLE_CYC-1.
REQ-017 IDLE_WAIT: Clk_En=1, Ack=0; Req high -> ON with Ack=1 after the same edge (no re-wake); counter zero with Req low -> OFF, Clk_En=0.
REQ-018 Idle timeout: Req low continuously from edge t SHALL give Clk_En=0 after edge t+IDLE_CYC.
REQ-019 If Req rises and the counter reaches zero on the same edge in IDLE_WAIT, Req SHALL win (-> ON).
REQ-020 A Req pulse that drops during WAKE SHALL still complete WAKE and then follow REQ-014; no early abort.
REQ-021 Force_On=1 SHALL pass CLK through on every Gated_CLK; FSMs, Ack and Clk_En SHALL continue unaffected by Force_On.
REQ-022 Gate cell: effective enable (Clk_En | Force_On) SHALL be captured by a latch transparent while CLK=0; Gated_CLK = CLK AND latched enable. Gated_CLK SHALL NOT glitch or truncate a high phase.
REQ-023 Domains SHALL NOT interact; simultaneous requests on all domains SHALL be served in parallel with identical latency.
REQ-024 Busy SHALL be combinational OR of Clk_En.

Reset
REQ-025 RST high SHALL asynchronously force every FSM to OFF, counters to 0, Ack=0, Clk_En=0 and the gate latches to 0, giving Gated_CLK=0 unless Force_On=1.
REQ-026 RST asserted mid-WAKE or mid-ON SHALL drop Gated_CLK no later than the next CLK low phase, with no partial pulse.
REQ-027 After RST deasserts, the first edge SHALL sample Req normally per REQ-013.

Structure
REQ-028 Shared package clk_gate_pkg SHALL hold the FSM state typedef (2-bit enum), the counter width constant (8) and the parameter defaults.
REQ-029 The latch+AND gate SHALL be a sub-module clk_gate_cell (ports CLK, RST, En, Gated_CLK), instantiated N_DOM times; the FSM SHALL be a generate loop inside clk_gate_ctrl.

Verification
REQ-030 Defaults; Req[0] high at edge 10 -> Clk_En[0]=1 after edge 10, Ack[0]=1 after edge 12, Gated_CLK[0] first pulse in cycle 11.
REQ-031 Req[0] low at edge 20 after ON -> Ack[0]=0 after edge 20, Clk_En[0]=0 after edge 36; Gated_CLK[0] has no pulse after cycle 36.
REQ-032 Req[1] low at edge 20, high again at edge 30 -> Ack[1]=1 after edge 30, Clk_En[1] stays 1 throughout, and no WAKE is re-entered.
REQ-033 Req[2] one-cycle pulse at edge 5 -> WAKE until edge 7, IDLE_WAIT, Clk_En[2]=0 after edge 23, Ack[2] never 1.
REQ-034 All Req high, then RST pulsed mid-WAKE -> all outputs 0 immediately; Gated_CLK has no runt pulse (checked by a pulse-width assertion ≥ half period).
REQ-035 Force_On=1 with all Req=0 -> all Gated_CLK toggle, Ack=0 and Clk_En=0; Force_On deasserted while CLK is high -> the current pulse completes at full width.
